// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin two-port sequencer for an asynchronous latch-based data memory
module data_memory_arbiter #(
  parameter int D_ADDR_W        = 12,
  parameter int DATA_W          = 8,
  parameter int WR_PULSE_CYCLES = 1,
  parameter int RD_WAIT_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          req_we,
  input  logic [D_ADDR_W-1:0] req_addr0,
  input  logic [D_ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0]   req_wdata0,
  input  logic [DATA_W-1:0]   req_wdata1,
  output logic [1:0]          ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [D_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_write_enable,
  output logic                mem_output_enable,
  input  logic [DATA_W-1:0]   mem_read_data
);
  localparam int CW = $clog2((WR_PULSE_CYCLES > RD_WAIT_CYCLES ? WR_PULSE_CYCLES : RD_WAIT_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic grant, last_grant, pick;
  always_comb begin
    pick = &req ? ~last_grant : req[1];
    nxt = state;
    case (state)
      IDLE:    nxt = ~|req ? IDLE : req_we[pick] ? SETUP : READ;
      SETUP:   nxt = WRITE;
      WRITE:   nxt = cnt == '0 ? HOLD : WRITE;
      HOLD:    nxt = IDLE;
      READ:    nxt = cnt == '0 ? DONE : READ;
      default: nxt = IDLE;
    endcase
    cnt_nxt = nxt != state ? (nxt == WRITE ? CW'(WR_PULSE_CYCLES - 1) : CW'(RD_WAIT_CYCLES - 1)) : cnt - CW'(1);
  end
  // memory pins are registered from the next state so the async memory never sees decode glitches
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      cnt               <= '0;
      grant             <= 1'b0;
      last_grant        <= 1'b1;
      mem_addr          <= '0;
      mem_wdata         <= '0;
      rdata             <= '0;
      ack               <= 2'b00;
      busy              <= 1'b0;
      mem_write_enable  <= 1'b0;
      mem_output_enable <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && |req) begin
        grant      <= pick;
        last_grant <= pick;
        mem_addr   <= pick ? req_addr1 : req_addr0;
        mem_wdata  <= pick ? req_wdata1 : req_wdata0;
      end
      if (state == READ && cnt == '0) rdata <= mem_read_data;
      mem_write_enable  <= nxt == WRITE;
      mem_output_enable <= nxt == READ;
      busy              <= nxt != IDLE;
      ack               <= (nxt == HOLD || nxt == DONE) ? 2'b01 << grant : 2'b00;
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed and random checks of two arbiter configurations against a timeline model
module tb_data_memory_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar c = 0; c < 2; c++) begin : cfg
    localparam int WR = c ? 3 : 1;
    localparam int RD = c ? 2 : 1;
    logic rst, busy, we, oe, chk_on, fin;
    logic [1:0] req, req_we, ack;
    logic [11:0] a0, a1, maddr;
    logic [7:0] w0, w1, rdata, mwd, mrd;
    logic [7:0] mem [4096] = '{default: 8'h00};
    logic [7:0] rmem [4096] = '{default: 8'h00};

    data_memory_arbiter #(.D_ADDR_W(12), .DATA_W(8), .WR_PULSE_CYCLES(WR), .RD_WAIT_CYCLES(RD)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we),
      .req_addr0(a0), .req_addr1(a1), .req_wdata0(w0), .req_wdata1(w1),
      .ack(ack), .rdata(rdata), .busy(busy),
      .mem_addr(maddr), .mem_wdata(mwd),
      .mem_write_enable(we), .mem_output_enable(oe), .mem_read_data(mrd));

    // latch memory: a bogus value off the read window exposes mistimed captures
    assign mrd = oe ? mem[maddr] : 8'hEE;
    always @(posedge clk) if (we) mem[maddr] <= mwd;

    // transaction timeline model: t counts cycles since the grant edge, len is the ack cycle
    int t = 0, len = 0;
    logic mg = 1'b0, mlast = 1'b1, mwr = 1'b0;
    logic [11:0] ea = '0;
    logic [7:0] ew = '0, er = '0;
    always @(posedge clk) begin
      if (rst) begin
        t = 0; mlast = 1'b1; ea = '0; ew = '0; er = '0;
      end else if (t == 0) begin
        if (|req) begin
          mg = (req == 2'b11) ? ~mlast : req[1];
          mlast = mg;
          mwr = req_we[mg];
          ea = mg ? a1 : a0;
          ew = mg ? w1 : w0;
          if (mwr) rmem[ea] = ew;
          len = mwr ? WR + 2 : RD + 1;
          t = 1;
        end
      end else if (t == len) t = 0;
      else begin
        t++;
        if (!mwr && t == len) er = rmem[ea];
      end
    end

    always @(negedge clk) if (chk_on) begin
      logic [1:0] eack;
      eack = (t != 0 && t == len) ? (mg ? 2'b10 : 2'b01) : 2'b00;
      check($sformatf("c%0d.ack", c), 32'(ack), 32'(eack));
      check($sformatf("c%0d.busy", c), 32'(busy), 32'(t != 0));
      check($sformatf("c%0d.we", c), 32'(we), 32'(mwr && t >= 2 && t <= WR + 1));
      check($sformatf("c%0d.oe", c), 32'(oe), 32'(!mwr && t >= 1 && t <= RD));
      check($sformatf("c%0d.addr", c), 32'(maddr), 32'(ea));
      check($sformatf("c%0d.wdata", c), 32'(mwd), 32'(ew));
      check($sformatf("c%0d.rdata", c), 32'(rdata), 32'(er));
      check($sformatf("c%0d.we_oe_excl", c), 32'(we && oe), 0);
    end

    initial begin
      int n;
      chk_on = 1'b0; fin = 1'b0;
      rst = 1'b1; req = '0; req_we = '0; a0 = '0; a1 = '0; w0 = '0; w1 = '0;
      @(negedge clk);
      chk_on = 1'b1;
      check($sformatf("c%0d.rst_state", c), {busy, we, oe, ack, maddr, rdata}, 0);
      rst = 1'b0;
      // write from port 0
      req_we[0] = 1'b1; a0 = 12'h123; w0 = 8'hA5; req[0] = 1'b1;
      for (int k = 1; k <= WR + 2; k++) begin
        @(negedge clk);
        check($sformatf("c%0d.wr_we%0d", c, k), 32'(we), 32'(k >= 2 && k <= WR + 1));
        check($sformatf("c%0d.wr_addr%0d", c, k), 32'(maddr), 32'h123);
        check($sformatf("c%0d.wr_data%0d", c, k), 32'(mwd), 32'hA5);
        check($sformatf("c%0d.wr_ack%0d", c, k), 32'(ack), k == WR + 2 ? 1 : 0);
        if (k == WR + 2) req[0] = 1'b0;
      end
      @(negedge clk);
      check($sformatf("c%0d.idle_gap", c), 32'(busy), 0);
      // read back from port 1
      req_we[1] = 1'b0; a1 = 12'h123; req[1] = 1'b1;
      for (int k = 1; k <= RD + 1; k++) begin
        @(negedge clk);
        check($sformatf("c%0d.rd_oe%0d", c, k), 32'(oe), 32'(k <= RD));
        check($sformatf("c%0d.rd_we%0d", c, k), 32'(we), 0);
        check($sformatf("c%0d.rd_ack%0d", c, k), 32'(ack), k == RD + 1 ? 2 : 0);
        if (k == RD + 1) begin
          check($sformatf("c%0d.rd_data", c), 32'(rdata), 32'hA5);
          req[1] = 1'b0;
        end
      end
      @(negedge clk);
      // address changes after grant must not reach the memory
      req_we[0] = 1'b1; a0 = 12'h010; w0 = 8'h3C; req[0] = 1'b1;
      for (int k = 1; k <= WR + 2; k++) begin
        @(negedge clk);
        a0 = 12'h020; w0 = 8'h77;
        check($sformatf("c%0d.hold_addr%0d", c, k), 32'(maddr), 32'h010);
        check($sformatf("c%0d.hold_data%0d", c, k), 32'(mwd), 32'h3C);
        if (k == WR + 2) req[0] = 1'b0;
      end
      @(negedge clk);
      // reset in the middle of the write pulse
      req_we[0] = 1'b1; a0 = 12'hFFF; w0 = 8'h99; req[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("c%0d.pre_rst_we", c), 32'(we), 1);
      rst = 1'b1;
      @(negedge clk);
      check($sformatf("c%0d.rst_mid", c), {busy, we, oe, ack}, 0);
      rst = 1'b0; req = '0;
      @(negedge clk);
      // both ports requesting continuously alternate, starting with port 0
      req_we = 2'b00; a0 = 12'h123; a1 = 12'h010; req = 2'b11;
      for (int k = 0; k < 4; k++) begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
          check($sformatf("c%0d.rr_onehot", c), 32'(ack == 2'b11), 0);
        end while (ack == 2'b00 && n < 50);
        check($sformatf("c%0d.rr_order%0d", c, k), 32'(ack), k % 2 ? 2 : 1);
        req = req & ~ack;
        @(negedge clk);
        req = 2'b11;
      end
      req = 2'b00;
      // random traffic on a small address window so reads hit earlier writes
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
          if (req[p] && ack[p]) req[p] = 1'b0;
          else if (req[p] && t != 0 && int'(mg) == p && $urandom_range(1, 0) == 1) begin
            if (p == 0) begin a0 = 12'($urandom_range(15, 0)); w0 = 8'($urandom); end
            else begin a1 = 12'($urandom_range(15, 0)); w1 = 8'($urandom); end
            req_we[p] = ~req_we[p];
          end else if (!req[p] && $urandom_range(2, 0) == 0) begin
            req_we[p] = 1'($urandom);
            if (p == 0) begin a0 = 12'($urandom_range(15, 0)); w0 = 8'($urandom); end
            else begin a1 = 12'($urandom_range(15, 0)); w1 = 8'($urandom); end
            req[p] = 1'b1;
          end
        end
      end
      req = 2'b00;
      repeat (10) @(negedge clk);
      fin = 1'b1;
    end
  end

  initial begin
    int i;
    i = 0;
    while (!(cfg[0].fin && cfg[1].fin) && i < 20000) begin
      @(posedge clk);
      i++;
    end
    if (!(cfg[0].fin && cfg[1].fin)) check("timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Sequences and shares the asynchronous, latch-based data memory between two requesters.
  - Port 0: CPU core load/store unit.
  - Port 1: debug/loader port.
- Registers each granted transaction and drives the memory control pins with a fixed setup/pulse/hold write sequence and a timed read window.
- Captures read data from the memory's tri-state read bus into a register.
- Sits between the requesters and the memory; it is the only driver of the memory's address, write-data, write_enable and output_enable pins.

Parameters:
- D_ADDR_W, 12, data address width.
- DATA_W, 8, data word width.
- WR_PULSE_CYCLES, 1, cycles write_enable is held high; legal range 1 or more.
- RD_WAIT_CYCLES, 1, cycles output_enable is held high before capture; legal range 1 or more.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-port request; bit i belongs to port i.
- req_we  in  2  per-port access type: 1 = write, 0 = read.
- req_addr0 / req_addr1  in  D_ADDR_W  per-port address.
- req_wdata0 / req_wdata1  in  DATA_W  per-port write data.
- ack  out  2  per-port one-cycle completion pulse.
- rdata  out  DATA_W  read data; shared by both ports and valid only with a read ack.
- busy  out  1  high whenever the FSM is not in IDLE.
- mem_addr  out  D_ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_write_enable  out  1  memory write enable.
- mem_output_enable  out  1  memory output enable.
- mem_read_data  in  DATA_W  memory tri-state read bus.

Behaviour:
- Reset: on any clock edge with rst high, the following take effect on that edge.
  - FSM goes to IDLE.
  - ack, busy, mem_write_enable and mem_output_enable go to 0.
  - mem_addr, mem_wdata and rdata go to 0.
  - last_grant goes to 1, so port 0 wins the first tie.
  - Reset mid-transaction abandons it with no ack. If reset lands during WRITE, write_enable drops on that edge.
- FSM states:
  - IDLE: arbitrate.
    - No req → stay in IDLE.
    - Exactly one req → grant that port.
    - Both req → round-robin: grant the port not equal to last_grant.
    - On grant: register the port's addr into mem_addr, its wdata into mem_wdata, and its we. Update last_grant.
    - Next state: SETUP if the access is a write, READ if it is a read.
  - SETUP: 1 cycle; write_enable=0, addr/data stable → WRITE.
  - WRITE: write_enable=1 for WR_PULSE_CYCLES cycles, counted by a down-counter → HOLD.
  - HOLD: 1 cycle; write_enable=0, addr/data unchanged; ack[grant]=1 → IDLE.
  - READ: output_enable=1 for RD_WAIT_CYCLES cycles. On the last cycle's edge, capture mem_read_data into rdata → DONE.
  - DONE: 1 cycle; output_enable=0; ack[grant]=1 with rdata valid → IDLE.
- Latency, measured from the IDLE edge that samples the request:
  - Write ack appears WR_PULSE_CYCLES+2 cycles later.
  - Read ack appears RD_WAIT_CYCLES+1 cycles later.
  - Minimum spacing between back-to-back grants: ack cycle + 1 IDLE cycle.
- Handshake:
  - A requester holds req, we, addr and wdata stable until its ack.
  - It must drop req in the cycle after ack. If req is still high in the following IDLE, it is treated as a new request.
  - Request inputs are ignored outside IDLE; mem_addr and mem_wdata are changed only on grant.
- Invariants:
  - mem_write_enable and mem_output_enable are never high in the same cycle.
  - mem_addr is constant from SETUP/READ entry through ack.
  - ack is one-hot or zero.
  - rdata holds its last captured value between read acks; a write does not change it.
- Counter width: $clog2 of max(WR_PULSE_CYCLES, RD_WAIT_CYCLES)+1; the counter reloads on every state entry.

Test Plan:
- Reset, then write from port 0 (addr 0x123, wdata 0xA5), default params → write_enable high exactly 1 cycle with mem_addr=0x123 and mem_wdata=0xA5 stable one cycle before and after; ack[0] at sample+3.
- Read of 0x123 from port 1, memory model returns 0xA5 → output_enable high 1 cycle; ack[1] at sample+2 with rdata=0xA5; write_enable stays 0 throughout.
- Both ports request continuously for 4 transactions after reset → grant order 0,1,0,1; never two acks in one cycle.
- WR_PULSE_CYCLES=3, RD_WAIT_CYCLES=2 → write_enable high 3 cycles, write ack at sample+5; read ack at sample+3.
- Assert rst during WRITE → write_enable 0 on that edge, no ack, busy 0; next request is granted to port 0 and completes normally.
- Port 0 changes addr mid-transaction (0x010 → 0x020) → mem_addr stays 0x010 until ack.
